// File: rtl/mmio_avmm_sequencer_if.sv
// MMIO command/response streams plus the Avalon-MM master port of the sequencer.
// "master" is the sequencer's view; "slave" is the view of the front end and CSR fabric around it.
interface mmio_avmm_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
);
    logic [ADDR_W+DATA_W+1:0] cmd_data;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [DATA_W-1:0]        rsp_data;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ADDR_W-1:0]        avmm_address;
    logic                     avmm_read;
    logic                     avmm_write;
    logic [DATA_W-1:0]        avmm_writedata;
    logic [DATA_W/8-1:0]      avmm_byteenable;
    logic                     avmm_waitrequest;
    logic [DATA_W-1:0]        avmm_readdata;
    logic                     avmm_readdatavalid;

    modport master (
        input  cmd_data, cmd_valid, rsp_ready,
        input  avmm_waitrequest, avmm_readdata, avmm_readdatavalid,
        output cmd_ready, rsp_data, rsp_valid,
        output avmm_address, avmm_read, avmm_write, avmm_writedata, avmm_byteenable
    );

    modport slave (
        output cmd_data, cmd_valid, rsp_ready,
        output avmm_waitrequest, avmm_readdata, avmm_readdatavalid,
        input  cmd_ready, rsp_data, rsp_valid,
        input  avmm_address, avmm_read, avmm_write, avmm_writedata, avmm_byteenable
    );
endinterface

// File: rtl/mmio_avmm_sequencer.sv
// Issues MMIO commands as Avalon-MM reads/writes, credit-limits outstanding reads and
// returns read data in order, substituting an all-ones response for reads that never complete.
module mmio_avmm_sequencer #(
    parameter int AVMM_ADDR_WIDTH   = 16,
    parameter int AVMM_DATA_WIDTH   = 64,
    parameter int MAX_PENDING_READS = 64,
    parameter int RD_TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk,
    input  logic                                SoftReset_n,
    mmio_avmm_sequencer_if.master               bus,
    output logic [$clog2(MAX_PENDING_READS):0]  pending_reads,
    output logic                                timeout_event,
    output logic [15:0]                         timeout_count
);
    localparam int AW = AVMM_ADDR_WIDTH;
    localparam int DW = AVMM_DATA_WIDTH;
    localparam int CW = $clog2(MAX_PENDING_READS) + 1;
    // Pointers wrap naturally, so MAX_PENDING_READS is expected to be a power of two.
    localparam int PW = $clog2(MAX_PENDING_READS);
    localparam int TW = $clog2(RD_TIMEOUT_CYCLES);
    localparam logic [CW-1:0] MAX_CREDITS = CW'(MAX_PENDING_READS);
    localparam logic [TW-1:0] TIMER_LOAD  = TW'(RD_TIMEOUT_CYCLES - 1);

    logic          issue_valid_q, issue_valid_d;
    logic          is_read_q, is_read_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [7:0]    be_q, be_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] pending_q, pending_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   tcount_q, tcount_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [DW-1:0] mem_q [MAX_PENDING_READS];

    logic          cmd_is_read, cmd_is_32;
    logic [AW-1:0] cmd_addr;
    logic          avmm_read, avmm_write, issue_fire, rd_fire, cmd_ready, cmd_accept;
    logic          rdv_accept, expire, push, pop, rsp_valid;
    logic [DW-1:0] push_data;

    assign cmd_is_read = bus.cmd_data[AW+DW+1];
    assign cmd_is_32   = bus.cmd_data[AW+DW];
    assign cmd_addr    = bus.cmd_data[AW+DW-1:DW];

    assign avmm_write = issue_valid_q & ~is_read_q;
    assign avmm_read  = issue_valid_q & is_read_q & (pending_q < MAX_CREDITS);
    assign issue_fire = (avmm_read | avmm_write) & ~bus.avmm_waitrequest;
    assign rd_fire    = avmm_read & ~bus.avmm_waitrequest;
    assign cmd_ready  = SoftReset_n & (~issue_valid_q | issue_fire);
    assign cmd_accept = bus.cmd_valid & cmd_ready;

    // Data arriving with nothing in flight is a late answer to a timed-out read.
    assign rdv_accept = bus.avmm_readdatavalid & (inflight_q != '0);
    assign expire     = (inflight_q != '0) & ~bus.avmm_readdatavalid & (timer_q == '0);
    assign push       = rdv_accept | expire;
    assign push_data  = expire ? {DW{1'b1}} : bus.avmm_readdata;
    assign rsp_valid  = fifo_cnt_q != '0;
    assign pop        = rsp_valid & bus.rsp_ready;

    always_comb begin
        issue_valid_d = issue_valid_q;
        is_read_d     = is_read_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        if (cmd_accept) begin
            issue_valid_d = 1'b1;
            is_read_d     = cmd_is_read;
            addr_d        = cmd_addr;
            wdata_d       = bus.cmd_data[DW-1:0];
            be_d          = !cmd_is_32 ? 8'hFF : (cmd_addr[2] ? 8'hF0 : 8'h0F);
        end else if (issue_fire) begin
            issue_valid_d = 1'b0;
        end

        inflight_d = inflight_q + CW'(rd_fire) - CW'(push);
        pending_d  = pending_q + CW'(rd_fire) - CW'(pop);

        // Down-counter reloads whenever the in-flight window restarts.
        if ((inflight_q == '0) || bus.avmm_readdatavalid || expire)
            timer_d = TIMER_LOAD;
        else
            timer_d = timer_q - 1'b1;

        tcount_d = tcount_q;
        if (expire && (tcount_q != 16'hFFFF))
            tcount_d = tcount_q + 16'd1;

        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            issue_valid_q <= 1'b0;
            is_read_q     <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            inflight_q    <= '0;
            pending_q     <= '0;
            timer_q       <= TIMER_LOAD;
            tcount_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            is_read_q     <= is_read_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            inflight_q    <= inflight_d;
            pending_q     <= pending_d;
            timer_q       <= timer_d;
            tcount_q      <= tcount_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= push_data;
    end

    assign bus.cmd_ready       = cmd_ready;
    assign bus.rsp_valid       = rsp_valid;
    assign bus.rsp_data        = mem_q[rd_ptr_q];
    assign bus.avmm_address    = addr_q;
    assign bus.avmm_read       = avmm_read;
    assign bus.avmm_write      = avmm_write;
    assign bus.avmm_writedata  = wdata_q;
    assign bus.avmm_byteenable = be_q;
    assign pending_reads       = pending_q;
    assign timeout_event       = expire;
    assign timeout_count       = tcount_q;
endmodule

// File: tb/tb_mmio_avmm_sequencer.sv
// Directed bench for mmio_avmm_sequencer: a per-cycle vector table for basic traffic,
// then hand-written sequences for waitrequest, credits, timeout and reset.
module tb_mmio_avmm_sequencer;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int MPR = 4;
    localparam int TO = 16;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] pending;
    logic          tev;
    logic [15:0]   tcnt;
    int            n_cmp = 0;
    int            n_err = 0;
    int            wr_fires = 0;

    mmio_avmm_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mmio_avmm_sequencer #(
        .AVMM_ADDR_WIDTH(AW), .AVMM_DATA_WIDTH(DW),
        .MAX_PENDING_READS(MPR), .RD_TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .SoftReset_n(rst_n), .bus(bus),
        .pending_reads(pending), .timeout_event(tev), .timeout_count(tcnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.avmm_write && !bus.avmm_waitrequest) wr_fires++;

    typedef struct {
        logic          cv;
        logic [81:0]   cd;
        logic          rdv;
        logic [63:0]   rdata;
        logic          rr;
        logic          e_wr;
        logic          e_rd;
        logic [15:0]   e_addr;
        logic [7:0]    e_be;
        logic          e_crdy;
        logic          e_rv;
        logic [63:0]   e_rsp;
        logic [2:0]    e_pend;
    } vec_t;

    function automatic logic [81:0] mk(input logic rd, input logic b32,
                                       input logic [15:0] a, input logic [63:0] d);
        return {rd, b32, a, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_data = '0;
        bus.rsp_ready = 1'b0;
        bus.avmm_waitrequest = 1'b0;
        bus.avmm_readdata = '0;
        bus.avmm_readdatavalid = 1'b0;
    endtask

    function automatic logic [63:0] dk(input int k);
        return 64'hC0DE_0000_0000_0000 | 64'(k);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        int   w0;
        logic [81:0] W64, R32, W32;
        W64 = mk(1'b0, 1'b0, 16'h0040, 64'h1122334455667788);
        R32 = mk(1'b1, 1'b1, 16'h0014, 64'h0);
        W32 = mk(1'b0, 1'b1, 16'h0008, 64'hABCD0123_ABCD0123);
        //          cv    cd   rdv   rdata                  rr    wr    rd    addr      be     crdy  rv    rsp                    pend
        vecs[0]  = '{1'b1, W64, 1'b0, 64'h0,                1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 64'h0,                3'd0};
        vecs[1]  = '{1'b1, R32, 1'b0, 64'h0,                1'b1, 1'b1, 1'b0, 16'h0040, 8'hFF, 1'b1, 1'b0, 64'h0,                3'd0};
        vecs[2]  = '{1'b0, R32, 1'b0, 64'h0,                1'b1, 1'b0, 1'b1, 16'h0014, 8'hF0, 1'b1, 1'b0, 64'h0,                3'd0};
        vecs[3]  = '{1'b0, R32, 1'b0, 64'h0,                1'b1, 1'b0, 1'b0, 16'h0014, 8'hF0, 1'b1, 1'b0, 64'h0,                3'd1};
        vecs[4]  = '{1'b0, R32, 1'b0, 64'h0,                1'b1, 1'b0, 1'b0, 16'h0014, 8'hF0, 1'b1, 1'b0, 64'h0,                3'd1};
        vecs[5]  = '{1'b0, R32, 1'b1, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b0, 1'b0, 16'h0014, 8'hF0, 1'b1, 1'b0, 64'h0,                3'd1};
        vecs[6]  = '{1'b0, R32, 1'b0, 64'h0,                1'b0, 1'b0, 1'b0, 16'h0014, 8'hF0, 1'b1, 1'b1, 64'hDEADBEEF_CAFEF00D, 3'd1};
        vecs[7]  = '{1'b0, R32, 1'b0, 64'h0,                1'b1, 1'b0, 1'b0, 16'h0014, 8'hF0, 1'b1, 1'b1, 64'hDEADBEEF_CAFEF00D, 3'd1};
        vecs[8]  = '{1'b1, W32, 1'b0, 64'h0,                1'b1, 1'b0, 1'b0, 16'h0014, 8'hF0, 1'b1, 1'b0, 64'h0,                3'd0};
        vecs[9]  = '{1'b0, W32, 1'b0, 64'h0,                1'b1, 1'b1, 1'b0, 16'h0008, 8'h0F, 1'b1, 1'b0, 64'h0,                3'd0};
        vecs[10] = '{1'b0, W32, 1'b0, 64'h0,                1'b1, 1'b0, 1'b0, 16'h0008, 8'h0F, 1'b1, 1'b0, 64'h0,                3'd0};

        idle_inputs();
        #2;
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        chk("rst_avmm_read", 64'(bus.avmm_read), 64'(0));
        chk("rst_avmm_write", 64'(bus.avmm_write), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_pending", 64'(pending), 64'(0));
        chk("rst_addr", 64'(bus.avmm_address), 64'(0));
        chk("rst_be", 64'(bus.avmm_byteenable), 64'(0));
        chk("rst_wdata", bus.avmm_writedata, 64'(0));
        chk("rst_tcount", 64'(tcnt), 64'(0));
        cyc();
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            bus.cmd_valid = vecs[i].cv;
            bus.cmd_data = vecs[i].cd;
            bus.avmm_readdatavalid = vecs[i].rdv;
            bus.avmm_readdata = vecs[i].rdata;
            bus.rsp_ready = vecs[i].rr;
            #1;
            chk($sformatf("v%0d_write", i), 64'(bus.avmm_write), 64'(vecs[i].e_wr));
            chk($sformatf("v%0d_read", i), 64'(bus.avmm_read), 64'(vecs[i].e_rd));
            chk($sformatf("v%0d_addr", i), 64'(bus.avmm_address), 64'(vecs[i].e_addr));
            chk($sformatf("v%0d_be", i), 64'(bus.avmm_byteenable), 64'(vecs[i].e_be));
            chk($sformatf("v%0d_cmd_ready", i), 64'(bus.cmd_ready), 64'(vecs[i].e_crdy));
            chk($sformatf("v%0d_rsp_valid", i), 64'(bus.rsp_valid), 64'(vecs[i].e_rv));
            if (vecs[i].e_rv) chk($sformatf("v%0d_rsp_data", i), bus.rsp_data, vecs[i].e_rsp);
            chk($sformatf("v%0d_pending", i), 64'(pending), 64'(vecs[i].e_pend));
            cyc();
        end

        // Write held under waitrequest for 5 cycles, with a second write queued behind it
        idle_inputs();
        w0 = wr_fires;
        bus.cmd_valid = 1'b1;
        bus.cmd_data = mk(1'b0, 1'b0, 16'h0100, 64'hA5A5_0000_5A5A_FFFF);
        bus.avmm_waitrequest = 1'b1;
        #1 chk("wq_accept_ready", 64'(bus.cmd_ready), 64'(1));
        cyc();
        bus.cmd_data = mk(1'b0, 1'b0, 16'h0108, 64'h0123456789ABCDEF);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("wq%0d_write", k), 64'(bus.avmm_write), 64'(1));
            chk($sformatf("wq%0d_addr", k), 64'(bus.avmm_address), 64'h0100);
            chk($sformatf("wq%0d_wdata", k), bus.avmm_writedata, 64'hA5A5_0000_5A5A_FFFF);
            chk($sformatf("wq%0d_be", k), 64'(bus.avmm_byteenable), 64'hFF);
            chk($sformatf("wq%0d_cmd_ready", k), 64'(bus.cmd_ready), 64'(0));
            cyc();
        end
        bus.avmm_waitrequest = 1'b0;
        #1;
        chk("wq_release_write", 64'(bus.avmm_write), 64'(1));
        chk("wq_release_ready", 64'(bus.cmd_ready), 64'(1));
        cyc();
        bus.cmd_valid = 1'b0;
        #1;
        chk("wq_second_addr", 64'(bus.avmm_address), 64'h0108);
        chk("wq_second_wdata", bus.avmm_writedata, 64'h0123456789ABCDEF);
        cyc();
        #1;
        chk("wq_write_done", 64'(bus.avmm_write), 64'(0));
        chk("wq_fire_count", 64'(wr_fires - w0), 64'(2));
        cyc();

        // Credit limit: 5 reads with rsp_ready low, each answered one cycle after issue
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
            bus.cmd_valid = (k < 5);
            bus.cmd_data = mk(1'b1, 1'b0, 16'(16'h0200 + 8 * k), 64'h0);
            bus.avmm_readdatavalid = (k >= 2);
            bus.avmm_readdata = (k >= 2) ? dk(k - 2) : 64'h0;
            #1;
            chk($sformatf("cr%0d_pending", k), 64'(pending), 64'((k == 0) ? 0 : k - 1));
            if (k >= 1) chk($sformatf("cr%0d_read", k), 64'(bus.avmm_read), 64'((k < 5) ? 1 : 0));
            chk($sformatf("cr%0d_cmd_ready", k), 64'(bus.cmd_ready), 64'((k < 5) ? 1 : 0));
            cyc();
        end
        bus.avmm_readdatavalid = 1'b0;
        #1;
        chk("cr_stall_read", 64'(bus.avmm_read), 64'(0));
        chk("cr_head", bus.rsp_data, dk(0));
        chk("cr_full_pending", 64'(pending), 64'(4));
        cyc();
        bus.rsp_ready = 1'b1;
        #1 chk("cr_pop_cycle_read", 64'(bus.avmm_read), 64'(0));
        cyc();
        bus.rsp_ready = 1'b0;
        #1;
        chk("cr_fifth_read", 64'(bus.avmm_read), 64'(1));
        chk("cr_fifth_addr", 64'(bus.avmm_address), 64'h0220);
        chk("cr_after_pop_pending", 64'(pending), 64'(3));
        chk("cr_after_pop_head", bus.rsp_data, dk(1));
        cyc();
        bus.avmm_readdatavalid = 1'b1;
        bus.avmm_readdata = dk(4);
        #1 chk("cr_refill_pending", 64'(pending), 64'(4));
        cyc();
        bus.avmm_readdatavalid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            #1;
            chk($sformatf("cr_drain%0d_valid", j), 64'(bus.rsp_valid), 64'(1));
            chk($sformatf("cr_drain%0d_data", j), bus.rsp_data, dk(j));
            chk($sformatf("cr_drain%0d_pending", j), 64'(pending), 64'(5 - j));
            cyc();
        end
        bus.rsp_ready = 1'b0;
        #1;
        chk("cr_empty_valid", 64'(bus.rsp_valid), 64'(0));
        chk("cr_empty_pending", 64'(pending), 64'(0));
        cyc();

        // Read that is never answered times out after TO in-flight cycles
        idle_inputs();
        bus.cmd_valid = 1'b1;
        bus.cmd_data = mk(1'b1, 1'b0, 16'h0300, 64'h0);
        cyc();
        bus.cmd_valid = 1'b0;
        #1 chk("to_issue", 64'(bus.avmm_read), 64'(1));
        cyc();
        for (int t = 1; t <= TO; t++) begin
            #1 chk($sformatf("to_event_t%0d", t), 64'(tev), 64'((t == TO) ? 1 : 0));
            cyc();
        end
        #1;
        chk("to_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        chk("to_rsp_data", bus.rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("to_count", 64'(tcnt), 64'(1));
        chk("to_event_clear", 64'(tev), 64'(0));
        bus.rsp_ready = 1'b1;
        cyc();
        bus.rsp_ready = 1'b0;
        bus.avmm_readdatavalid = 1'b1;
        bus.avmm_readdata = 64'h1234;
        #1 chk("to_late_pending", 64'(pending), 64'(0));
        cyc();
        bus.avmm_readdatavalid = 1'b0;
        #1;
        chk("to_late_dropped", 64'(bus.rsp_valid), 64'(0));
        chk("to_late_count", 64'(tcnt), 64'(1));
        cyc();

        // Read data arriving exactly in the expiry cycle wins over the timeout
        bus.cmd_valid = 1'b1;
        bus.cmd_data = mk(1'b1, 1'b0, 16'h0308, 64'h0);
        cyc();
        bus.cmd_valid = 1'b0;
        cyc();
        for (int t = 1; t < TO; t++) cyc();
        bus.avmm_readdatavalid = 1'b1;
        bus.avmm_readdata = 64'h5555;
        #1 chk("tie_no_event", 64'(tev), 64'(0));
        cyc();
        bus.avmm_readdatavalid = 1'b0;
        #1;
        chk("tie_rsp_data", bus.rsp_data, 64'h5555);
        chk("tie_count", 64'(tcnt), 64'(1));
        bus.rsp_ready = 1'b1;
        cyc();
        bus.rsp_ready = 1'b0;
        #1 chk("tie_drained", 64'(bus.rsp_valid), 64'(0));
        cyc();

        // Reset with reads in flight, one response queued and a read held under waitrequest
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_data = mk(1'b1, 1'b0, 16'(16'h0400 + 8 * k), 64'h0);
            cyc();
        end
        bus.cmd_valid = 1'b0;
        bus.avmm_readdatavalid = 1'b1;
        bus.avmm_readdata = 64'hAAAA;
        cyc();
        bus.avmm_readdatavalid = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data = mk(1'b1, 1'b0, 16'h0418, 64'h0);
        #1;
        chk("pre_rst_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        chk("pre_rst_pending", 64'(pending), 64'(3));
        cyc();
        bus.cmd_valid = 1'b0;
        bus.avmm_waitrequest = 1'b1;
        #1 chk("pre_rst_read", 64'(bus.avmm_read), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("mid_rst_read", 64'(bus.avmm_read), 64'(0));
        chk("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        chk("mid_rst_pending", 64'(pending), 64'(0));
        chk("mid_rst_addr", 64'(bus.avmm_address), 64'(0));
        chk("mid_rst_tcount", 64'(tcnt), 64'(0));
        cyc();
        rst_n = 1'b1;
        bus.avmm_waitrequest = 1'b0;
        bus.avmm_readdatavalid = 1'b1;
        bus.avmm_readdata = 64'hBBBB;
        cyc();
        bus.avmm_readdatavalid = 1'b0;
        #1;
        chk("post_rst_late_dropped", 64'(bus.rsp_valid), 64'(0));
        chk("post_rst_pending", 64'(pending), 64'(0));
        bus.cmd_valid = 1'b1;
        bus.cmd_data = mk(1'b1, 1'b0, 16'h0500, 64'h0);
        cyc();
        bus.cmd_valid = 1'b0;
        #1;
        chk("fresh_read", 64'(bus.avmm_read), 64'(1));
        chk("fresh_addr", 64'(bus.avmm_address), 64'h0500);
        cyc();
        bus.avmm_readdatavalid = 1'b1;
        bus.avmm_readdata = 64'h600D;
        cyc();
        bus.avmm_readdatavalid = 1'b0;
        #1;
        chk("fresh_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        chk("fresh_rsp_data", bus.rsp_data, 64'h600D);
        chk("fresh_pending", 64'(pending), 64'(1));
        bus.rsp_ready = 1'b1;
        cyc();
        bus.rsp_ready = 1'b0;
        #1;
        chk("fresh_popped_pending", 64'(pending), 64'(0));
        chk("fresh_popped_valid", 64'(bus.rsp_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mmio_avmm_sequencer.md
# mmio_avmm_sequencer

Sequencing controller between the MMIO command/response streams of the CCI-P MMIO front end and a single Avalon-MM master port feeding the AFU CSR fabric. Accepts packed MMIO commands, issues them as Avalon-MM reads and writes with waitrequest flow control, limits outstanding reads with a credit counter, and returns read data in order. Reads that never complete are terminated with a synthesized all-ones response, so the host never hangs on an MMIO read.

## Interface
- AVMM_ADDR_WIDTH, 16: byte address width of the command and the AVMM port.
- AVMM_DATA_WIDTH, 64: data width. Fixed at 64; byteenable logic assumes 8 lanes.
- MAX_PENDING_READS, 64: read credits; also the response FIFO depth.
- RD_TIMEOUT_CYCLES, 1024: idle cycles on in-flight reads before a timeout response.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- SoftReset_n  in  1  asynchronous, active-low reset.
- cmd_data  in  AVMM_ADDR_WIDTH+AVMM_DATA_WIDTH+2  packed command, MSB first: is_read, is_32bit, addr, write_data.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- rsp_data  out  AVMM_DATA_WIDTH  read response data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- avmm_address  out  AVMM_ADDR_WIDTH  byte address.
- avmm_read, avmm_write  out  1 each  AVMM request strobes.
- avmm_writedata  out  AVMM_DATA_WIDTH  write data.
- avmm_byteenable  out  AVMM_DATA_WIDTH/8  byte lanes.
- avmm_waitrequest  in  1  slave stall.
- avmm_readdata  in  AVMM_DATA_WIDTH  read data.
- avmm_readdatavalid  in  1  read data valid.
- pending_reads  out  $clog2(MAX_PENDING_READS)+1  reads issued but not yet popped from rsp.
- timeout_event  out  1  one-cycle pulse per synthesized timeout response.
- timeout_count  out  16  saturating count of timeouts.

## Operation
- Issue register: holds one command (issue_valid).
  - A command is accepted into the issue register on cmd_valid & cmd_ready.
  - cmd_ready = SoftReset_n & (~issue_valid | issue_fire).
- Request strobes:
  - avmm_write = issue_valid & ~is_read.
  - avmm_read = issue_valid & is_read & (pending_reads < MAX_PENDING_READS).
  - issue_fire = (avmm_read | avmm_write) & ~avmm_waitrequest.
- The AVMM outputs stay stable while a strobe is held under waitrequest.
- Field mapping:
  - avmm_address = addr.
  - avmm_writedata = write_data, unmodified (upstream already replicates 32-bit data).
  - avmm_byteenable = 8'hFF when the command is 64-bit.
  - For 32-bit commands, avmm_byteenable = addr[2] ? 8'hF0 : 8'h0F.
- Counters:
  - inflight counts reads issued and awaiting readdatavalid.
  - pending_reads counts reads issued and not yet popped from rsp.
  - Both increment on a read issue_fire.
  - inflight decrements on an accepted readdatavalid or on a timeout.
  - pending_reads decrements on a rsp pop.
  - Simultaneous increment and decrement leaves the count unchanged.
- Response FIFO: depth MAX_PENDING_READS, show-ahead.
  - rsp_valid = FIFO not empty; rsp_data = FIFO head.
  - Credit gating guarantees the FIFO never overflows.
- avmm_readdatavalid handling:
  - When inflight > 0, push avmm_readdata.
  - When inflight == 0 (late data after a timeout), drop it with no push.
- Timeout timer:
  - Counts while inflight > 0.
  - Clears on any accepted readdatavalid, or when inflight == 0.
  - On reaching RD_TIMEOUT_CYCLES: push {AVMM_DATA_WIDTH{1'b1}}, decrement inflight, pulse timeout_event, increment timeout_count (saturating at 16'hFFFF), clear the timer.
  - If readdatavalid and timer expiry occur in the same cycle, readdatavalid wins and no timeout is raised.
- Writes are posted: no response, no credit.
- Reset (SoftReset_n low, asynchronous):
  - issue_valid, both counters, timer, FIFO, timeout_count, timeout_event, avmm_read, avmm_write, and rsp_valid are all 0.
  - cmd_ready is 0; the address, data and byteenable outputs are 0.
  - Reset mid-operation discards held commands and queued responses. Late readdatavalid after reset is dropped because inflight == 0.

## Timing
- Command accepted at cycle N: the AVMM strobe is asserted at N+1. Back-to-back accepts are allowed whenever the slave has no waitrequest (one command per cycle).
- avmm_readdatavalid at cycle M: rsp_valid at M+1.
- Timeout: expiry when the timer reaches RD_TIMEOUT_CYCLES consecutive cycles with inflight > 0 and no readdatavalid. timeout_event pulses in the expiry cycle; the all-ones response is visible the next cycle.
- With pending_reads == MAX_PENDING_READS, a held read stalls with avmm_read low and cmd_ready low. The read is issued in the cycle after the pop that frees a credit.
- Responses are strictly in issue order.

## Test plan
- 64-bit write {is_read=0, is_32bit=0, addr=16'h0040, data=64'h1122334455667788}, no waitrequest -> at N+1 avmm_write=1, address 16'h0040, byteenable 8'hFF, for one cycle.
- 32-bit read at addr 16'h0014, slave returns 64'hDEADBEEF_CAFEF00D three cycles after issue -> byteenable 8'hF0; rsp_data=64'hDEADBEEF_CAFEF00D one cycle after readdatavalid; pending_reads returns 1 -> 0 on pop.
- waitrequest held for 5 cycles during a write -> strobe and fields stable for all 5 cycles, cmd_ready low, single completion.
- MAX_PENDING_READS=4, rsp_ready=0, 5 reads -> 4 issued, 5th held with avmm_read=0. One pop issues the 5th on the next cycle; FIFO never exceeds 4.
- RD_TIMEOUT_CYCLES=16, slave never answers one read -> timeout_event at cycle 16, rsp_data=64'hFFFF_FFFF_FFFF_FFFF, timeout_count=1. A late readdatavalid is dropped with no extra rsp.
- Assert SoftReset_n low with 2 reads in flight and 1 response queued -> rsp_valid, avmm_read, cmd_ready and pending_reads go to 0 immediately. After release, a fresh read completes normally.
